pc_seq_rv32i: RTL and testbench

- Multi-cycle fetch/commit sequencer that drives the next_pc input of the 32-bit RV32I program counter register.
- The PC register loads next_pc on every clock, so this block holds the PC by driving next_pc = pc. It advances the PC only when an instruction commits.
- It handshakes with instruction memory, waits for the execute stage, and selects between sequential (pc+4), branch/jump target and trap vector.

---
 rtl/pc_seq_rv32i.sv | 128 ++++++++++++
 tb/tb_pc_seq_rv32i.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_rv32i.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_rv32i
// Brief    : Fetch/commit sequencer driving next_pc of the RV32I PC register.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq_rv32i #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_TRAP  = 2'b10
    } state_t;

    localparam logic [7:0] c_cnt_last     = 8'(TIMEOUT - 1);
    localparam logic [1:0] c_cause_misal  = 2'b01;
    localparam logic [1:0] c_cause_tmo    = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [1:0]  r_cause;
    logic [1:0]  w_cause_nxt;
    logic        w_commit;
    logic        w_misaligned;
    logic [31:0] w_seq_pc;

    assign w_commit     = ex_done & ~stall;
    assign w_misaligned = (branch_target[1:0] != 2'b00);
    assign w_seq_pc     = pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= 8'd0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        next_pc     = pc;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        trap        = 1'b0;

        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                // Ack takes priority over an expiring timeout in the same cycle.
                if (imem_ack) begin
                    w_state_nxt = S_EXEC;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_TRAP;
                    w_cnt_nxt   = 8'd0;
                    w_cause_nxt = c_cause_tmo;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (w_commit) begin
                    if (!branch_taken) begin
                        next_pc     = w_seq_pc;
                        w_state_nxt = S_FETCH;
                    end else if (w_misaligned) begin
                        w_cause_nxt = c_cause_misal;
                        w_state_nxt = S_TRAP;
                    end else begin
                        next_pc     = branch_target;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                trap        = 1'b1;
                next_pc     = TRAP_VEC;
                w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // Reset overrides everything so the PC register loads RESET_VEC.
        if (reset) begin
            next_pc     = RESET_VEC;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            trap        = 1'b0;
        end
    end

    assign imem_addr  = pc;
    assign trap_cause = r_cause;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_rv32i.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_seq_rv32i
// Brief    : Directed plus randomized bench for pc_seq_rv32i with a PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_seq_rv32i;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        ex_done;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [1:0]  state;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0 fetching, 1 executing, 2 trapping.
    int          m_phase;
    int          m_waited;
    logic [1:0]  m_cause;
    logic [31:0] m_pc;

    pc_seq_rv32i #(.RESET_VEC(RV), .TRAP_VEC(TV), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .ex_done(ex_done), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    // The PC register this block feeds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RV;
        else       pc <= next_pc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_waited = 0;
        m_cause  = 2'b00;
        m_pc     = RV;
    endtask

    // One clock: compare all outputs with the model, then advance the model.
    task automatic tick();
        logic [31:0] e_next;
        logic        e_req, e_val, e_trap, e_commit;
        #1;
        e_commit = ex_done && !stall;
        e_req = 1'b0; e_val = 1'b0; e_trap = 1'b0;
        e_next = m_pc;
        if (reset) begin
            e_next = RV;
        end else if (m_phase == 0) begin
            e_req = 1'b1;
        end else if (m_phase == 1) begin
            e_val = 1'b1;
            if (e_commit && !branch_taken)
                e_next = m_pc + 32'd4;
            else if (e_commit && branch_target[1:0] == 2'b00)
                e_next = branch_target;
        end else begin
            e_trap = 1'b1;
            e_next = TV;
        end
        chk("next_pc", next_pc, e_next);
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_val});
        chk("trap", {31'd0, trap}, {31'd0, e_trap});
        chk("trap_cause", {30'd0, trap_cause}, {30'd0, m_cause});
        chk("state", {30'd0, state}, m_phase);
        chk("pc", pc, m_pc);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_pc = e_next;
            if (m_phase == 0) begin
                if (imem_ack) begin
                    m_phase = 1; m_waited = 0;
                end else if (m_waited == TO - 1) begin
                    m_phase = 2; m_waited = 0; m_cause = 2'b10;
                end else begin
                    m_waited++;
                end
            end else if (m_phase == 1) begin
                if (e_commit) begin
                    if (branch_taken && branch_target[1:0] != 2'b00) begin
                        m_phase = 2; m_cause = 2'b01;
                    end else begin
                        m_phase = 0;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc [5];
        logic        exp_iv [5];
        exp_pc = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        exp_iv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; imem_ack = 1'b1; ex_done = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        @(posedge clk); #1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Back-to-back sequential instructions, two cycles each.
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("seq_pc", pc, exp_pc[i]);
            chk("seq_instr_valid", {31'd0, instr_valid}, {31'd0, exp_iv[i]});
            tick();
        end

        branch_taken = 1'b1; branch_target = 32'h1000;
        tick();
        branch_taken = 1'b0;
        tick();

        // Stall holds the commit.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_hold", next_pc, 32'h1000);
            tick();
        end
        stall = 1'b0;
        settle();
        chk("stall_release", next_pc, 32'h1004);
        tick();
        chk("stall_pc", pc, 32'h1004);

        repeat (5) tick();
        chk("pre_branch_pc", pc, 32'h100C);
        branch_taken = 1'b1; branch_target = 32'hC000;
        tick();
        chk("branch_pc", pc, 32'hC000);
        settle();
        chk("branch_fetch_addr", imem_addr, 32'hC000);
        branch_taken = 1'b0;
        tick();
        tick();
        chk("branch_seq_pc", pc, 32'hC004);

        // Misaligned redirect traps.
        tick();
        branch_taken = 1'b1; branch_target = 32'hC002;
        settle();
        chk("misal_hold", next_pc, 32'hC004);
        tick();
        chk("misal_trap", {31'd0, trap}, 32'd1);
        chk("misal_cause", {30'd0, trap_cause}, 32'd1);
        branch_taken = 1'b0;
        settle();
        chk("trap_vec", next_pc, TV);
        tick();
        chk("trap_pc", pc, TV);
        chk("trap_one_cycle", {31'd0, trap}, 32'd0);

        // Fetch timeout, then ack on the last counting cycle.
        imem_ack = 1'b0;
        repeat (TO) tick();
        chk("tmo_trap", {31'd0, trap}, 32'd1);
        chk("tmo_cause", {30'd0, trap_cause}, 32'd2);
        tick();
        chk("tmo_pc", pc, TV);
        repeat (TO - 1) tick();
        imem_ack = 1'b1;
        tick();
        chk("late_ack_state", {30'd0, state}, 32'd1);
        chk("late_ack_no_trap", {31'd0, trap}, 32'd0);

        // Wrap around the top of the address space.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        chk("wrap_pc", pc, 32'h0);

        // Asynchronous reset in the middle of execute.
        repeat (3) tick();
        chk("pre_reset_pc", pc, 32'h4);
        reset = 1'b1;
        settle();
        chk("rst_next_pc", next_pc, RV);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cause", {30'd0, trap_cause}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        model_reset();
        tick();
        reset = 1'b0;
        settle();
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        tick();

        // Randomized traffic; a window of withheld acks forces timeouts.
        for (int i = 0; i < 600; i++) begin
            imem_ack      = ($urandom_range(0, 9) < 4) && !(i >= 200 && i < 260);
            ex_done       = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 2) == 0);
            branch_target = $urandom;
            if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
